// File: rtl/obi_buffer.sv
// Generic first-word-fall-through FIFO with a level output.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: caller must not push when full or pop when empty.
module obi_buffer_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop_vld)      cnt <= cnt + 1'b1;
            else if (!push_vld && pop_vld) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
endmodule

// OBI request buffer: FIFO-decoupled req/gnt with an outstanding-transaction cap.
// Latency: accepted request reaches the secondary next cycle; response adds RESP_REG cycles.
// Backpressure: ctrl_gnt_o drops when the FIFO is full or MAX_OUTSTANDING requests are in flight.
module obi_buffer #(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int DEPTH           = 4,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int RESP_REG        = 1,
    localparam int BE_W            = DATA_WIDTH / 8,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ctrl_req_i,
    output logic                  ctrl_gnt_o,
    input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
    input  logic                  ctrl_we_i,
    input  logic [BE_W-1:0]       ctrl_be_i,
    input  logic [DATA_WIDTH-1:0] ctrl_wdata_i,
    output logic                  ctrl_rvalid_o,
    output logic [DATA_WIDTH-1:0] ctrl_rdata_o,
    output logic                  secondary_req_o,
    input  logic                  secondary_gnt_i,
    output logic [ADDR_WIDTH-1:0] secondary_addr_o,
    output logic                  secondary_we_o,
    output logic [BE_W-1:0]       secondary_be_o,
    output logic [DATA_WIDTH-1:0] secondary_wdata_o,
    input  logic                  secondary_rvalid_i,
    input  logic [DATA_WIDTH-1:0] secondary_rdata_i,
    output logic [OW-1:0]         outstanding_o,
    output logic                  err_o
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = ((OW > LW) ? OW : LW) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t          push_req;
    req_t          head_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          push_vld;
    logic          pop_vld;
    logic [OW-1:0] outstanding_q;
    logic          err_q;
    logic          spurious;
    logic          resp_in_reg;
    logic          resp_done;
    logic [CW-1:0] not_owed;

    assign ctrl_gnt_o = rst_ni && !fifo_full && (outstanding_q < OW'(MAX_OUTSTANDING));
    assign push_vld   = ctrl_req_i && ctrl_gnt_o;
    assign pop_vld    = !fifo_empty && secondary_gnt_i;
    assign push_req   = '{addr: ctrl_addr_i, we: ctrl_we_i, be: ctrl_be_i, wdata: ctrl_wdata_i};

    obi_buffer_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push_vld),
        .push_dat (push_req),
        .pop_vld  (pop_vld),
        .pop_dat  (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign secondary_req_o   = !fifo_empty;
    assign secondary_addr_o  = head_req.addr;
    assign secondary_we_o    = head_req.we;
    assign secondary_be_o    = head_req.be;
    assign secondary_wdata_o = head_req.wdata;

    // Nothing is owed to the secondary when every counted request is still queued or already answered.
    assign not_owed = CW'(fifo_level) + CW'(resp_in_reg);
    assign spurious = secondary_rvalid_i && (CW'(outstanding_q) <= not_owed);

    generate
        if (RESP_REG != 0) begin : g_resp_reg
            logic                  rvalid_q;
            logic                  spur_q;
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rvalid_q <= 1'b0;
                    spur_q   <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= secondary_rvalid_i;
                    spur_q   <= spurious;
                    if (secondary_rvalid_i) rdata_q <= secondary_rdata_i;
                end
            end

            assign ctrl_rvalid_o = rvalid_q;
            assign ctrl_rdata_o  = rdata_q;
            assign resp_in_reg   = rvalid_q && !spur_q;
            assign resp_done     = rvalid_q && !spur_q;
        end else begin : g_resp_comb
            assign ctrl_rvalid_o = secondary_rvalid_i;
            assign ctrl_rdata_o  = secondary_rdata_i;
            assign resp_in_reg   = 1'b0;
            assign resp_done     = secondary_rvalid_i && !spurious;
        end
    endgenerate

    // Spurious responses are forwarded but never retire a counted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (push_vld && !resp_done)
                outstanding_q <= outstanding_q + 1'b1;
            else if (!push_vld && resp_done && (outstanding_q != '0))
                outstanding_q <= outstanding_q - 1'b1;
            if (spurious) err_q <= 1'b1;
        end
    end

    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_obi_buffer.sv
// Bench for obi_buffer: queue-based model checked every cycle plus directed literal checks.
module tb_obi_buffer;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } treq_t;

    logic        clk = 1'b0;
    logic        rst_n;
    // main DUT: DEPTH 4, MAX_OUTSTANDING 8, registered response
    logic        req, we, sgnt, srvalid;
    logic [31:0] addr, wdata, srdata;
    logic [3:0]  be;
    logic        gnt, rvalid, sreq, swe, err;
    logic [31:0] rdata, saddr, swdata;
    logic [3:0]  sbe;
    logic [3:0]  outst;
    // second DUT: MAX_OUTSTANDING 2, combinational response
    logic        b_req, b_we, b_sgnt, b_srvalid;
    logic [31:0] b_addr, b_wdata, b_srdata;
    logic [3:0]  b_be;
    logic        b_gnt, b_rvalid, b_sreq, b_swe, b_err;
    logic [31:0] b_rdata, b_saddr, b_swdata;
    logic [3:0]  b_sbe;
    logic [1:0]  b_outst;

    always #5 clk = ~clk;

    obi_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESP_REG(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ctrl_req_i(req), .ctrl_gnt_o(gnt), .ctrl_addr_i(addr), .ctrl_we_i(we), .ctrl_be_i(be),
        .ctrl_wdata_i(wdata), .ctrl_rvalid_o(rvalid), .ctrl_rdata_o(rdata),
        .secondary_req_o(sreq), .secondary_gnt_i(sgnt), .secondary_addr_o(saddr), .secondary_we_o(swe),
        .secondary_be_o(sbe), .secondary_wdata_o(swdata), .secondary_rvalid_i(srvalid),
        .secondary_rdata_i(srdata), .outstanding_o(outst), .err_o(err)
    );

    obi_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESP_REG(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .ctrl_req_i(b_req), .ctrl_gnt_o(b_gnt), .ctrl_addr_i(b_addr), .ctrl_we_i(b_we), .ctrl_be_i(b_be),
        .ctrl_wdata_i(b_wdata), .ctrl_rvalid_o(b_rvalid), .ctrl_rdata_o(b_rdata),
        .secondary_req_o(b_sreq), .secondary_gnt_i(b_sgnt), .secondary_addr_o(b_saddr), .secondary_we_o(b_swe),
        .secondary_be_o(b_sbe), .secondary_wdata_o(b_swdata), .secondary_rvalid_i(b_srvalid),
        .secondary_rdata_i(b_srdata), .outstanding_o(b_outst), .err_o(b_err)
    );

    int checks = 0;
    int errors = 0;

    // model of the main DUT
    treq_t       mq[$];
    int          m_out, m_issued;
    bit          m_rv, m_rspur, m_err;
    logic [31:0] m_rd;
    // end-to-end scoreboard and secondary responder
    bit          e2e_on, auto_on, last_pop;
    logic [31:0] last_pop_addr;
    logic [31:0] acc_q[$];
    logic [31:0] rsp_q[$];
    int          n_acc, n_rsp;

    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_issued = 0; m_rv = 0; m_rspur = 0; m_err = 0; m_rd = '0;
    endtask

    task automatic compare_all();
        bit e_sreq;
        if (!rst_n) model_reset();
        e_sreq = (mq.size() > 0);
        chk("gnt", gnt, rst_n && (mq.size() < DEPTH) && (m_out < MAXO));
        chk("sreq", sreq, e_sreq);
        chk("rvalid", rvalid, m_rv);
        chk("rdata", rdata, m_rd);
        chk("outstanding", outst, m_out);
        chk("err", err, m_err);
        if (e_sreq) begin
            chk("saddr", saddr, mq[0].addr);
            chk("swe", swe, mq[0].we);
            chk("sbe", sbe, mq[0].be);
            chk("swdata", swdata, mq[0].wdata);
        end
        if (e2e_on && rst_n && rvalid) begin
            if (acc_q.size() == 0) chk("e2e_extra_resp", 1, 0);
            else chk("e2e_rdata", rdata, resp_of(acc_q.pop_front()));
            n_rsp++;
        end
    endtask

    task automatic model_step();
        bit g, push, pop, spur, dec;
        last_pop = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        g    = (mq.size() < DEPTH) && (m_out < MAXO);
        push = req && g;
        pop  = (mq.size() > 0) && sgnt;
        spur = srvalid && (m_issued == 0);
        dec  = m_rv && !m_rspur;
        if (spur) m_err = 1;
        if (srvalid && !spur) m_issued--;
        if (pop) begin
            last_pop      = 1;
            last_pop_addr = mq[0].addr;
            void'(mq.pop_front());
            m_issued++;
        end
        if (push) begin
            mq.push_back('{addr: addr, we: we, be: be, wdata: wdata});
            if (e2e_on) begin
                acc_q.push_back(addr);
                n_acc++;
            end
        end
        m_out  = m_out + int'(push) - int'(dec);
        m_rv   = srvalid;
        m_rspur = spur;
        if (srvalid) m_rd = srdata;
    endtask

    task automatic drive_auto();
        if (last_pop) rsp_q.push_back(resp_of(last_pop_addr));
        srvalid = (rsp_q.size() > 0) && ($urandom_range(0, 2) != 0);
        srdata  = srvalid ? rsp_q.pop_front() : $urandom;
        sgnt    = $urandom_range(0, 1) != 0;
        req     = (n_acc < 100) && ($urandom_range(0, 3) != 0);
        addr    = {$urandom_range(0, 32'h3FFF), 2'b00};
        we      = $urandom_range(0, 1) != 0;
        be      = 4'($urandom_range(0, 15));
        wdata   = $urandom;
    endtask

    // one clock: check at negedge, advance model on inputs of this cycle, land #1 after posedge
    task automatic tick();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
        if (auto_on) drive_auto();
    endtask

    task automatic idle();
        req = 0; addr = '0; we = 0; be = 4'hF; wdata = '0;
        sgnt = 0; srvalid = 0; srdata = '0;
    endtask

    initial begin
        bit g_hist[6];
        bit done;
        logic [31:0] exp_a;
        idle();
        b_req = 0; b_addr = '0; b_we = 0; b_be = 4'hF; b_wdata = '0;
        b_sgnt = 0; b_srvalid = 0; b_srdata = '0;
        e2e_on = 0; auto_on = 0; n_acc = 0; n_rsp = 0;
        model_reset();

        // 1: reset with request held high
        rst_n = 0;
        req = 1; addr = 32'h100;
        repeat (3) tick();
        chk("t1_rst_gnt", gnt, 0);
        chk("t1_rst_sreq", sreq, 0);
        chk("t1_rst_outst", outst, 0);
        chk("t1_rst_err", err, 0);
        chk("t1_rst_rvalid", rvalid, 0);
        req = 0; rst_n = 1;
        #1;
        chk("t1_gnt_on_release", gnt, 1);
        tick();

        // 2: single read through the registered response path
        req = 1; addr = 32'h1000_0040; we = 0;
        chk("t2_gnt_c0", gnt, 1);
        tick();
        req = 0;
        chk("t2_sreq_c1", sreq, 1);
        chk("t2_saddr_c1", saddr, 32'h1000_0040);
        chk("t2_outst_c1", outst, 1);
        sgnt = 1;
        tick();
        sgnt = 0;
        chk("t2_sreq_c2", sreq, 0);
        tick();
        srvalid = 1; srdata = 32'hDEAD_BEEF;
        chk("t2_rvalid_c3", rvalid, 0);
        tick();
        srvalid = 0;
        chk("t2_rvalid_c4", rvalid, 1);
        chk("t2_rdata_c4", rdata, 32'hDEAD_BEEF);
        chk("t2_outst_c4", outst, 1);
        tick();
        chk("t2_outst_c5", outst, 0);
        chk("t2_rdata_hold", rdata, 32'hDEAD_BEEF);

        // 3: FIFO fills with the secondary stalled, then drains in order
        for (int i = 0; i < 6; i++) begin
            req = 1; addr = 32'(i * 4); we = 1; wdata = 32'(i + 32'h70);
            g_hist[i] = gnt;
            tick();
        end
        req = 0;
        for (int i = 0; i < 6; i++) chk($sformatf("t3_gnt_%0d", i), g_hist[i], (i < 4) ? 1 : 0);
        chk("t3_gnt_full", gnt, 0);
        chk("t3_outst", outst, 4);
        sgnt = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_issue_%0d", i), {sreq, saddr}, {1'b1, 32'(i * 4)});
            tick();
        end
        sgnt = 0;
        chk("t3_empty", sreq, 0);
        srvalid = 1;
        for (int i = 0; i < 4; i++) begin
            srdata = 32'(i);
            tick();
        end
        srvalid = 0;
        tick();
        chk("t3_outst_end", outst, 0);

        // 4: outstanding cap of 2 on the second DUT, combinational response
        b_sgnt = 1; b_req = 1; b_addr = 32'h20;
        chk("t4_gnt_c0", b_gnt, 1);
        tick();
        b_addr = 32'h24;
        chk("t4_gnt_c1", b_gnt, 1);
        tick();
        b_addr = 32'h28;
        chk("t4_gnt_c2", b_gnt, 0);
        chk("t4_outst_c2", b_outst, 2);
        tick();
        b_srvalid = 1; b_srdata = 32'h0000_2020;
        #1;
        chk("t4_gnt_c3", b_gnt, 0);
        chk("t4_rvalid_c3", b_rvalid, 1);
        chk("t4_rdata_c3", b_rdata, 32'h0000_2020);
        tick();
        b_srvalid = 0;
        chk("t4_gnt_c4", b_gnt, 1);
        chk("t4_outst_c4", b_outst, 1);
        tick();
        b_req = 0;
        chk("t4_outst_c5", b_outst, 2);
        tick();
        b_srvalid = 1;
        repeat (2) tick();
        b_srvalid = 0;
        #1;
        chk("t4_outst_end", b_outst, 0);
        chk("t4_err", b_err, 0);

        // 5: accept and response in the same cycle at outstanding 1
        req = 1; addr = 32'h50; we = 0;
        tick();
        req = 0; sgnt = 1;
        tick();
        sgnt = 0; srvalid = 1; srdata = 32'h55;
        tick();
        srvalid = 0; req = 1; addr = 32'h54;
        chk("t5_gnt", gnt, 1);
        chk("t5_rvalid", rvalid, 1);
        chk("t5_outst_before", outst, 1);
        tick();
        req = 0;
        chk("t5_outst_after", outst, 1);
        sgnt = 1;
        tick();
        sgnt = 0; srvalid = 1; srdata = 32'h59;
        tick();
        srvalid = 0;
        repeat (2) tick();
        chk("t5_outst_end", outst, 0);

        // 5b: 100 random in-order transactions
        e2e_on = 1; auto_on = 1;
        drive_auto();
        done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            tick();
            done = (n_acc >= 100) && (m_out == 0) && (rsp_q.size() == 0) && !rvalid;
        end
        auto_on = 0;
        idle();
        tick();
        e2e_on = 0;
        chk("t5_rand_done", done, 1);
        chk("t5_rand_resp_count", n_rsp, 100);
        chk("t5_rand_err", err, 0);

        // 6: spurious response sets the sticky error; reset clears it
        srvalid = 1; srdata = 32'h66;
        chk("t6_err_before", err, 0);
        tick();
        srvalid = 0;
        chk("t6_err_set", err, 1);
        chk("t6_outst", outst, 0);
        chk("t6_forwarded", {rvalid, rdata}, {1'b1, 32'h66});
        tick();
        chk("t6_err_sticky", err, 1);
        chk("t6_outst_hold", outst, 0);
        rst_n = 0;
        #1;
        chk("t6_err_cleared", err, 0);
        tick();
        rst_n = 1;
        tick();
        exp_a = 32'h0;
        chk("t6_err_after", {err, outst}, {1'b0, exp_a[3:0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
